// File: rtl/fft_pkg.sv
// fft_pkg: constants and FSM state encoding for the radix-2 DIT FFT stage
// sequencer (256 points, 8 stages, 4 butterflies per issued group).
// Shared by the sequencer top, its address generator and the neighbouring
// data buffer / twiddle engine blocks.
package fft_pkg;
    localparam int LOG2N   = 8;                          // stages; 2**LOG2N points
    localparam int LANES   = 4;                          // butterflies per group
    localparam int ADDR_W  = 8;                          // data-buffer address width
    localparam int TW_W    = 7;                          // twiddle index width
    localparam int OUTST_W = 6;                          // outstanding-group counter width
    localparam int LVL_W   = 3;                          // stage index width
    localparam int GRP_W   = 5;                          // group index width
    localparam int LANE_W  = 2;                          // butterfly-in-group index width
    localparam int GROUPS  = (1 << LOG2N) / (2 * LANES); // groups per stage (32)
    localparam int CNT_W   = 16;                         // performance counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational butterfly address / twiddle generator.
// For stage s and butterfly b = LANES*group + k (h = 1 << s):
//   low  = ((b >> s) << (s+1)) | (b & (h-1)),  high = low + h
//   tw   = (b & (h-1)) << (LOG2N-1-s)
// Ports:
//   level_i  in  stage index 0..7
//   group_i  in  group index 0..31
//   k_i      in  butterfly index inside the group 0..3
//   low_o    out low-leg data address
//   high_o   out high-leg data address
//   tw_o     out twiddle index (power of W256)
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [LVL_W-1:0]  level_i,
    input  logic [GRP_W-1:0]  group_i,
    input  logic [LANE_W-1:0] k_i,
    output logic [ADDR_W-1:0] low_o,
    output logic [ADDR_W-1:0] high_o,
    output logic [TW_W-1:0]   tw_o
);
    logic [ADDR_W-1:0] bfly;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] low;
    logic [TW_W-1:0]   offset;

    assign bfly = ADDR_W'({group_i, k_i});
    assign span = ADDR_W'(1) << level_i;
    assign mask = span - ADDR_W'(1);

    // Insert a zero at bit position s of the butterfly number.
    assign low    = (((bfly >> level_i) << 1) << level_i) | (bfly & mask);
    // Offset inside the butterfly block is below 2**s <= 128, so it fits TW_W.
    assign offset = TW_W'(bfly & mask);

    assign low_o  = low;
    assign high_o = low + span;
    assign tw_o   = offset << (LVL_W'(LOG2N - 1) - level_i);
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks the 8 radix-2 DIT stages of a 256-point FFT over
// a 4-lane butterfly array. Per stage it issues 32 groups back to back, then
// waits for every issued group to return before starting the next stage, so
// a stage never reads data the previous stage has not yet written.
// Optional build macro: FFT_SEQ_PERF_EN adds the cycle_cnt output.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   start_flush  in   pulse: input buffer holds a full frame
//   bfly_ready   in   butterfly result strobe, one per issued group
//   bfly_start   out  group issue strobe
//   bfly_addr    out  8 data addresses; lane 2k = low leg, 2k+1 = high leg
//   tw_idx       out  4 twiddle indices, butterfly k at [7k+6:7k]
//   level        out  current stage
//   output_start out  pulse: frame complete
//   busy         out  frame in flight
//   err_overrun  out  sticky protocol error flag
//   cycle_cnt    out  (FFT_SEQ_PERF_EN only) cycles spent on the last frame
module fft_stage_sequencer
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_flush,
    input  logic                        bfly_ready,
    output logic                        bfly_start,
    output logic [2*LANES*ADDR_W-1:0]   bfly_addr,
    output logic [LANES*TW_W-1:0]       tw_idx,
    output logic [LVL_W-1:0]            level,
    output logic                        output_start,
    output logic                        busy,
    output logic                        err_overrun
`ifdef FFT_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]            cycle_cnt
`endif
);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LOG2N - 1);

    fsm_state_e                  state_q, state_d;
    logic [LVL_W-1:0]            lvl_q, lvl_d;
    logic [GRP_W-1:0]            grp_q, grp_d;
    logic [OUTST_W-1:0]          outst_q, outst_d;
    logic                        bfly_start_q, bfly_start_d;
    logic [2*LANES*ADDR_W-1:0]   addr_q, addr_d;
    logic [LANES*TW_W-1:0]       tw_q, tw_d;
    logic                        output_start_q, output_start_d;
    logic                        busy_q, busy_d;
    logic                        err_q, err_d;
    logic                        accept_start;
    logic                        ready_ok;

    // One generator per lane, fed with the next-state level/group so the
    // registered addresses line up with the registered issue strobe.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ADDR_W-1:0] lane_low;
        logic [ADDR_W-1:0] lane_high;
        logic [TW_W-1:0]   lane_tw;

        fft_addr_gen u_addr_gen (
            .level_i (lvl_d),
            .group_i (grp_d),
            .k_i     (LANE_W'(gi)),
            .low_o   (lane_low),
            .high_o  (lane_high),
            .tw_o    (lane_tw)
        );

        assign addr_d[(2*gi)*ADDR_W   +: ADDR_W] = lane_low;
        assign addr_d[(2*gi+1)*ADDR_W +: ADDR_W] = lane_high;
        assign tw_d[gi*TW_W +: TW_W]             = lane_tw;
    end

    // DONE accepts a new frame just like IDLE; busy is already low there.
    assign accept_start = start_flush && ((state_q == IDLE) || (state_q == DONE));
    // A result strobe with nothing outstanding is dropped so the counter never wraps.
    assign ready_ok     = bfly_ready && (outst_q != '0);

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        grp_d   = grp_q;
        outst_d = outst_q + OUTST_W'(bfly_start_q) - OUTST_W'(ready_ok);
        err_d   = err_q | (bfly_ready && (outst_q == '0)) | (start_flush && busy_q);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept_start) begin
                    state_d = ISSUE;
                    lvl_d   = '0;
                    grp_d   = '0;
                end
            end
            ISSUE: begin
                if (grp_q == LAST_GRP) begin
                    state_d = DRAIN;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DRAIN: begin
                // Look at the post-update count so the last result of a stage
                // releases the next stage in the same cycle it arrives.
                if (outst_d == '0) begin
                    if (lvl_q == LAST_LVL) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        lvl_d   = lvl_q + 1'b1;
                        grp_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bfly_start_d   = (state_d == ISSUE);
        busy_d         = (state_d == ISSUE) || (state_d == DRAIN);
        output_start_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            lvl_q          <= '0;
            grp_q          <= '0;
            outst_q        <= '0;
            bfly_start_q   <= 1'b0;
            addr_q         <= '0;
            tw_q           <= '0;
            output_start_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            lvl_q          <= lvl_d;
            grp_q          <= grp_d;
            outst_q        <= outst_d;
            bfly_start_q   <= bfly_start_d;
            output_start_q <= output_start_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            // Addresses only change with an issue; otherwise hold the last group.
            if (bfly_start_d) begin
                addr_q <= addr_d;
                tw_q   <= tw_d;
            end
        end
    end

    assign bfly_start   = bfly_start_q;
    assign bfly_addr    = addr_q;
    assign tw_idx       = tw_q;
    assign level        = lvl_q;
    assign output_start = output_start_q;
    assign busy         = busy_q;
    assign err_overrun  = err_q;

`ifdef FFT_SEQ_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The accepting cycle counts as the first; the DONE cycle is the last
    // counted, after which the value holds until the next frame.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_start) begin
            cnt_d = CNT_W'(1);
        end else if ((state_q != IDLE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed bench for fft_stage_sequencer.
// A table of {level, group, addresses, twiddles} records is checked against
// groups captured during a full frame; hand-written sequences cover reset
// mid-frame, ready latency, overrun errors and back-to-back ready.
module tb_fft_stage_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_flush;
    logic        bfly_ready;
    logic        bfly_start;
    logic [63:0] bfly_addr;
    logic [27:0] tw_idx;
    logic [2:0]  level;
    logic        output_start;
    logic        busy;
    logic        err_overrun;
`ifdef FFT_SEQ_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    always #5 clk = ~clk;

    fft_stage_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start_flush  (start_flush),
        .bfly_ready   (bfly_ready),
        .bfly_start   (bfly_start),
        .bfly_addr    (bfly_addr),
        .tw_idx       (tw_idx),
        .level        (level),
        .output_start (output_start),
        .busy         (busy),
        .err_overrun  (err_overrun)
`ifdef FFT_SEQ_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt)
`endif
    );

    typedef struct {
        int          lvl;
        int          grp;
        logic [63:0] addr;
        logic [27:0] tw;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] cap_addr [256];
    logic [27:0] cap_tw   [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic vec_t mk(input int l, input int g,
                                input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int t0, input int t1, input int t2, input int t3);
        vec_t v;
        v.lvl  = l;
        v.grp  = g;
        v.addr = {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.tw   = {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
        return v;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Run one frame with a ready model of the given latency. Optionally
    // inject a second start_flush at cycle dup_at and capture all groups.
    task automatic run_frame(input string tag, input int lat, input int dup_at,
                             input bit capture, input bit exp_err);
        bit hist [64];
        int lvl_cnt [8];
        int rdy_done [8];
        int issued = 0, readied = 0, last_rdy = 0, busy_cyc = 0;
        int max_o = 0, bad_order = 0, os_cycle = -1, os_count = 0;
        for (int i = 0; i < 8; i++) begin
            lvl_cnt[i]  = 0;
            rdy_done[i] = 0;
        end
        for (int i = 0; i < 64; i++) hist[i] = 1'b0;
        @(negedge clk);
        start_flush = 1'b1;
        bfly_ready  = 1'b0;
        for (int n = 1; n < 1000; n++) begin
            @(negedge clk);
            start_flush = (n == dup_at);
            if (busy) busy_cyc++;
            hist[n % 64] = bfly_start;
            if (bfly_start) begin
                if (int'(level) != issued / 32) bad_order++;
                if (level != 3'd0 && lvl_cnt[level] == 0 && n <= rdy_done[level - 1]) bad_order++;
                if (capture && issued < 256) begin
                    cap_addr[issued] = bfly_addr;
                    cap_tw[issued]   = tw_idx;
                end
                lvl_cnt[level]++;
                issued++;
            end
            bfly_ready = (n > lat) ? hist[(n - lat) % 64] : 1'b0;
            if (bfly_ready) begin
                readied++;
                last_rdy = n;
                if (readied % 32 == 0 && readied <= 256) rdy_done[readied / 32 - 1] = n;
            end
            if (issued - readied > max_o) max_o = issued - readied;
            if (output_start) begin
                os_count++;
                if (os_cycle < 0) os_cycle = n;
            end
            if (os_cycle >= 0 && n >= os_cycle + 3) break;
        end
        bfly_ready  = 1'b0;
        start_flush = 1'b0;
        check({tag, "_finished_in_time"}, 64'(os_cycle >= 0), 64'd1);
        check({tag, "_issues_total"}, 64'(issued), 64'd256);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_issues_level%0d", tag, i), 64'(lvl_cnt[i]), 64'd32);
        check({tag, "_stage_order_violations"}, 64'(bad_order), 64'd0);
        check({tag, "_output_start_pulses"}, 64'(os_count), 64'd1);
        check({tag, "_output_start_cycle"}, 64'(os_cycle), 64'(8 * (32 + lat) + 1));
        check({tag, "_output_start_after_drain"}, 64'(os_cycle - last_rdy), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(8 * (32 + lat)));
        check({tag, "_max_outstanding"}, 64'(max_o), 64'(lat));
        check({tag, "_err_overrun"}, 64'(err_overrun), 64'(exp_err));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
`ifdef FFT_SEQ_PERF_EN
        check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(8 * (32 + lat) + 2));
`endif
    endtask

    // Start a frame and pull reset while level 3, group 10 is being issued.
    task automatic reset_mid_issue();
        bit hist [64];
        int lvl_cnt [8];
        bit found = 1'b0;
        int os_seen = 0, starts_seen = 0;
        for (int i = 0; i < 8; i++) lvl_cnt[i] = 0;
        for (int i = 0; i < 64; i++) hist[i] = 1'b0;
        @(negedge clk);
        start_flush = 1'b1;
        for (int n = 1; n < 400 && !found; n++) begin
            @(negedge clk);
            start_flush  = 1'b0;
            hist[n % 64] = bfly_start;
            if (bfly_start) begin
                if (level == 3'd3 && lvl_cnt[3] == 10) found = 1'b1;
                lvl_cnt[level]++;
            end
            bfly_ready = (!found && n > 1) ? hist[(n - 1) % 64] : 1'b0;
            if (found) reset = 1'b1;
        end
        check("rst_reached_l3_g10", 64'(found), 64'd1);
        @(negedge clk);
        bfly_ready = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bfly_start", 64'(bfly_start), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_output_start", 64'(output_start), 64'd0);
        check("rst_bfly_addr", bfly_addr, 64'd0);
        check("rst_tw_idx", 64'(tw_idx), 64'd0);
        check("rst_err_overrun", 64'(err_overrun), 64'd0);
`ifdef FFT_SEQ_PERF_EN
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (output_start) os_seen++;
            if (bfly_start) starts_seen++;
        end
        check("rst_no_output_start", 64'(os_seen), 64'd0);
        check("rst_no_issue_after", 64'(starts_seen), 64'd0);
    endtask

    initial begin
        vecs[0] = mk(0,  0,   0,   1,   2,   3,   4,   5,   6,   7,    0,   0,   0,   0);
        vecs[1] = mk(1,  0,   0,   2,   1,   3,   4,   6,   5,   7,    0,  64,   0,  64);
        vecs[2] = mk(7,  0,   0, 128,   1, 129,   2, 130,   3, 131,    0,   1,   2,   3);
        vecs[3] = mk(0, 31, 248, 249, 250, 251, 252, 253, 254, 255,    0,   0,   0,   0);
        vecs[4] = mk(2,  5,  40,  44,  41,  45,  42,  46,  43,  47,    0,  32,  64,  96);
        vecs[5] = mk(3, 10,  80,  88,  81,  89,  82,  90,  83,  91,    0,  16,  32,  48);
        vecs[6] = mk(7, 31, 124, 252, 125, 253, 126, 254, 127, 255,  124, 125, 126, 127);
        vecs[7] = mk(6, 17, 132, 196, 133, 197, 134, 198, 135, 199,    8,  10,  12,  14);
        vecs[8] = mk(4,  3,  12,  28,  13,  29,  14,  30,  15,  31,   96, 104, 112, 120);
        vecs[9] = mk(5,  9,  68, 100,  69, 101,  70, 102,  71, 103,   16,  20,  24,  28);

        reset       = 1'b1;
        start_flush = 1'b0;
        bfly_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("init_bfly_start", 64'(bfly_start), 64'd0);
        check("init_bfly_addr", bfly_addr, 64'd0);
        check("init_tw_idx", 64'(tw_idx), 64'd0);
        check("init_level", 64'(level), 64'd0);
        check("init_output_start", 64'(output_start), 64'd0);
        check("init_busy", 64'(busy), 64'd0);
        check("init_err_overrun", 64'(err_overrun), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a stage.
        reset_mid_issue();

        // Full frame at 5-cycle ready latency, capturing every group.
        run_frame("lat5", 5, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("addr_L%0d_G%0d", vecs[i].lvl, vecs[i].grp),
                  cap_addr[vecs[i].lvl * 32 + vecs[i].grp], vecs[i].addr);
            check($sformatf("tw_L%0d_G%0d", vecs[i].lvl, vecs[i].grp),
                  64'(cap_tw[vecs[i].lvl * 32 + vecs[i].grp]), 64'(vecs[i].tw));
        end
        check("addr_hold_after_frame", bfly_addr, vecs[6].addr);
        check("tw_hold_after_frame", 64'(tw_idx), 64'(vecs[6].tw));

        // Ready arriving with every issue: outstanding never above 1.
        run_frame("lat1", 1, 0, 1'b0, 1'b0);

        // Second start_flush in the middle of a frame.
        run_frame("dupstart", 5, 40, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("dupstart_err_sticky", 64'(err_overrun), 64'd1);

        // Spurious ready while idle, then a frame must still complete.
        pulse_reset();
        @(negedge clk);
        check("spur_err_before", 64'(err_overrun), 64'd0);
        bfly_ready = 1'b1;
        @(negedge clk);
        bfly_ready = 1'b0;
        @(negedge clk);
        check("spur_err_set", 64'(err_overrun), 64'd1);
        repeat (5) @(negedge clk);
        check("spur_err_sticky", 64'(err_overrun), 64'd1);
        check("spur_no_busy", 64'(busy), 64'd0);
        run_frame("spur", 5, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end
endmodule
